// File: rtl/adbg_pkg.sv
// Shared constants and helpers for the adbg module-select logic.
// The status chain is only built when ADBG_SELECT_STATUS_EN is defined.
package adbg_pkg;

  // Status word layout: ID field at the bottom, flag bits stacked directly above it.
  localparam int STAT_ID_LSB  = 0;
  localparam int STAT_VALID   = 0;
  localparam int STAT_ERR_RNG = 1;
  localparam int STAT_ERR_INH = 2;
  localparam int STAT_FLAGS   = 3;

  // Reserved module ID that selects the status chain instead of a module.
  function automatic int status_id(input int id_width);
    return (1 << id_width) - 1;
  endfunction

  // The select-command bit is the most recently shifted-in bit of the data register.
  function automatic int sel_cmd_pos(input int shift_len);
    return shift_len - 1;
  endfunction

endpackage

// File: rtl/adbg_status_chain.sv
// Capture/shift status register read over JTAG in status mode.
// Instantiated by adbg_chain_select only when ADBG_SELECT_STATUS_EN is defined.
module adbg_status_chain
  import adbg_pkg::*;
#(
  parameter int ID_WIDTH = 5
) (
  input  logic                           tck_i,
  input  logic                           trst_i,
  input  logic                           capture_i,
  input  logic                           shift_i,
  input  logic [ID_WIDTH+STAT_FLAGS-1:0] status_word_i,
  output logic                           tdo_o
);

  localparam int W = ID_WIDTH + STAT_FLAGS;

  logic [W-1:0] stat_sr;

  // Capture wins over shift; shifting drains LSB first with zero fill.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      stat_sr <= '0;
    end else if (capture_i) begin
      stat_sr <= status_word_i;
    end else if (shift_i) begin
      stat_sr <= {1'b0, stat_sr[W-1:1]};
    end
  end

  assign tdo_o = stat_sr[0];

endmodule

// File: rtl/adbg_chain_select.sv
// Debug module select: JTAG input shift chain, one-hot select decode, TDO mux and sticky errors.
// Optional status chain enabled with `define ADBG_SELECT_STATUS_EN.
module adbg_chain_select
  import adbg_pkg::*;
#(
  parameter int N_MODULES = 5,
  parameter int ID_WIDTH  = 5,
  parameter int SHIFT_LEN = 53
) (
  input  logic                 tck_i,
  input  logic                 trst_i,
  input  logic                 tdi_i,
  output logic                 tdo_o,
  input  logic                 shift_dr_i,
  input  logic                 capture_dr_i,
  input  logic                 update_dr_i,
  input  logic                 debug_select_i,
  output logic [SHIFT_LEN-1:0] data_register_o,
  input  logic [N_MODULES-1:0] module_tdo_i,
  input  logic [N_MODULES-1:0] module_inhibit_i,
  output logic [N_MODULES-1:0] module_select_o,
  output logic                 select_err_o
);

  localparam int                STAT_W    = ID_WIDTH + STAT_FLAGS;
  localparam int                CMD_BIT   = sel_cmd_pos(SHIFT_LEN);
  localparam logic [ID_WIDTH-1:0] STATUS_ID = ID_WIDTH'(status_id(ID_WIDTH));
  localparam logic [ID_WIDTH:0]   N_MOD_LIM = (ID_WIDTH+1)'(N_MODULES);

  logic [SHIFT_LEN-1:0] sr;
  logic [ID_WIDTH-1:0]  id_in;
  logic [ID_WIDTH-1:0]  id_reg;
  logic                 valid;
  logic                 err_inh;
  logic                 err_rng;
  logic                 select_cmd;
  logic                 sel_evt;
  logic                 inhibited;
  logic                 in_range;
  logic                 is_status_id;
  logic                 status_ok;
  logic                 status_mode;
  logic                 stat_tdo;
  logic                 err_clr;
  logic                 set_inh;
  logic                 set_rng;
  logic                 tdo_mod;
  logic [STAT_W-1:0]    status_word;

  assign select_cmd   = sr[CMD_BIT];
  assign id_in        = sr[CMD_BIT-1 -: ID_WIDTH];
  assign sel_evt      = update_dr_i & debug_select_i & select_cmd;
  assign inhibited    = |module_inhibit_i;
  assign in_range     = {1'b0, id_in} < N_MOD_LIM;
  assign is_status_id = (id_in == STATUS_ID);

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      sr <= '0;
    end else if (debug_select_i && shift_dr_i) begin
      sr <= {tdi_i, sr[SHIFT_LEN-1:1]};
    end
  end

  assign data_register_o = sr;

  // Every uninhibited select latches the ID; only in-range IDs drive a module select.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      id_reg <= '0;
      valid  <= 1'b1;
    end else if (sel_evt && !inhibited) begin
      id_reg <= id_in;
      valid  <= in_range;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_ID_LSB +: ID_WIDTH]   = id_reg;
    status_word[ID_WIDTH + STAT_VALID]     = valid;
    status_word[ID_WIDTH + STAT_ERR_RNG]   = err_rng;
    status_word[ID_WIDTH + STAT_ERR_INH]   = err_inh;
  end

`ifdef ADBG_SELECT_STATUS_EN
  logic stat_capture;
  logic stat_shift;

  assign status_ok    = is_status_id;
  assign status_mode  = ~valid & (id_reg == STATUS_ID);
  // Update outranks capture if the TAP ever raises both together.
  assign stat_capture = capture_dr_i & debug_select_i & ~update_dr_i & status_mode;
  assign stat_shift   = shift_dr_i & debug_select_i & status_mode;
  assign err_clr      = stat_capture;

  adbg_status_chain #(
    .ID_WIDTH (ID_WIDTH)
  ) u_status_chain (
    .tck_i         (tck_i),
    .trst_i        (trst_i),
    .capture_i     (stat_capture),
    .shift_i       (stat_shift),
    .status_word_i (status_word),
    .tdo_o         (stat_tdo)
  );
`else
  logic unused_status;

  assign status_ok     = 1'b0;
  assign status_mode   = 1'b0;
  assign stat_tdo      = 1'b0;
  assign err_clr       = sel_evt & ~inhibited & in_range;
  assign unused_status = ^{capture_dr_i, status_word, is_status_id};
`endif

  assign set_inh = sel_evt & inhibited;
  assign set_rng = sel_evt & ~inhibited & ~in_range & ~status_ok;

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      err_inh <= 1'b0;
      err_rng <= 1'b0;
    end else begin
      err_inh <= set_inh | (err_inh & ~err_clr);
      err_rng <= set_rng | (err_rng & ~err_clr);
    end
  end

  assign select_err_o = err_inh | err_rng;

  always_comb begin
    module_select_o = '0;
    tdo_mod         = 1'b0;
    for (int i = 0; i < N_MODULES; i++) begin
      if (valid && (id_reg == ID_WIDTH'(i))) begin
        module_select_o[i] = 1'b1;
        tdo_mod            = module_tdo_i[i];
      end
    end
  end

  assign tdo_o = valid ? tdo_mod : (status_mode & stat_tdo);

endmodule

// File: tb/tb_adbg_chain_select.sv
// Self-checking bench for adbg_chain_select: directed table, corner sequences and random traffic.
// Expectations follow ADBG_SELECT_STATUS_EN when it is defined for the build.
module tb_adbg_chain_select;

  localparam int NM = 5;
  localparam int IW = 5;
  localparam int SL = 53;

`ifdef ADBG_SELECT_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  localparam int S_NONE  = 0;
  localparam int S_SHIFT = 1;
  localparam int S_CAP   = 2;
  localparam int S_UPD   = 3;
  localparam int S_CU    = 4;

  logic          tck = 1'b0;
  logic          trst;
  logic          tdi;
  logic          tdo;
  logic          shift_dr;
  logic          capture_dr;
  logic          update_dr;
  logic          dsel;
  logic [SL-1:0] dr;
  logic [NM-1:0] mtdo;
  logic [NM-1:0] minh;
  logic [NM-1:0] msel;
  logic          serr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: data register as a bit queue (index = bit position).
  bit srq[$];
  bit statq[$];
  int m_id;
  bit m_valid;
  bit m_inh;
  bit m_rng;

  typedef struct {
    int         id;
    logic [4:0] inh;
    logic [4:0] exp_sel;
    logic       exp_err;
    logic       exp_tdo;
  } vec_t;

  vec_t tbl[6];

  always #5 tck = ~tck;

  adbg_chain_select #(
    .N_MODULES (NM),
    .ID_WIDTH  (IW),
    .SHIFT_LEN (SL)
  ) dut (
    .tck_i            (tck),
    .trst_i           (trst),
    .tdi_i            (tdi),
    .tdo_o            (tdo),
    .shift_dr_i       (shift_dr),
    .capture_dr_i     (capture_dr),
    .update_dr_i      (update_dr),
    .debug_select_i   (dsel),
    .data_register_o  (dr),
    .module_tdo_i     (mtdo),
    .module_inhibit_i (minh),
    .module_select_o  (msel),
    .select_err_o     (serr)
  );

  function automatic void modelReset();
    srq.delete();
    for (int k = 0; k < SL; k++) srq.push_back(1'b0);
    statq.delete();
    for (int k = 0; k < IW + 3; k++) statq.push_back(1'b0);
    m_id    = 0;
    m_valid = 1'b1;
    m_inh   = 1'b0;
    m_rng   = 1'b0;
  endfunction

  function automatic int srField(int msb, int w);
    int v = 0;
    for (int k = msb; k > msb - w; k--) v = v * 2 + int'(srq[k]);
    return v;
  endfunction

  function automatic bit mStatus();
    return STAT_EN && !m_valid && (m_id == 31);
  endfunction

  // One rising edge of the model, evaluated from pre-edge state.
  function automatic void modelEdge();
    bit st       = mStatus();
    bit cmd      = srq[SL-1];
    int id       = srField(SL - 2, IW);
    bit captured = 1'b0;
    if (dsel && update_dr && cmd) begin
      if (minh != 0) begin
        m_inh = 1'b1;
      end else if (id < NM) begin
        m_id = id; m_valid = 1'b1;
        if (!STAT_EN) begin m_inh = 1'b0; m_rng = 1'b0; end
      end else if (STAT_EN && id == 31) begin
        m_id = id; m_valid = 1'b0;
      end else begin
        m_id = id; m_valid = 1'b0; m_rng = 1'b1;
      end
    end else if (dsel && capture_dr && !update_dr && st) begin
      statq.delete();
      for (int k = 0; k < IW; k++) statq.push_back(bit'((m_id >> k) & 1));
      statq.push_back(m_valid);
      statq.push_back(m_rng);
      statq.push_back(m_inh);
      m_inh = 1'b0; m_rng = 1'b0;
      captured = 1'b1;
    end
    if (STAT_EN && dsel && shift_dr && st && !captured) begin
      void'(statq.pop_front());
      statq.push_back(1'b0);
    end
    if (dsel && shift_dr) begin
      void'(srq.pop_front());
      srq.push_back(tdi);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [63:0] e_dr = '0;
    logic [63:0] e_sel = '0;
    logic        e_tdo;
    for (int k = 0; k < SL; k++) e_dr[k] = srq[k];
    if (m_valid) e_sel = 64'(1) << m_id;
    e_tdo = m_valid ? mtdo[m_id] : (mStatus() ? statq[0] : 1'b0);
    checkOutput("data_register", 64'(dr), e_dr);
    checkOutput("module_select", 64'(msel), e_sel);
    checkOutput("select_err", 64'(serr), 64'(m_inh | m_rng));
    checkOutput("tdo", 64'(tdo), 64'(e_tdo));
  endtask

  task automatic applyStimulus(input logic t, input int strobe, input logic ds,
                               input logic [NM-1:0] mt, input logic [NM-1:0] mi);
    @(negedge tck);
    tdi        = t;
    shift_dr   = (strobe == S_SHIFT);
    capture_dr = (strobe == S_CAP) || (strobe == S_CU);
    update_dr  = (strobe == S_UPD) || (strobe == S_CU);
    dsel       = ds;
    mtdo       = mt;
    minh       = mi;
    @(posedge tck);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic shiftCommand(input int id, input logic [NM-1:0] mi);
    logic [SL-1:0] vec;
    vec          = {$urandom, $urandom};
    vec[SL-1]    = 1'b1;
    vec[SL-2 -: IW] = IW'(id);
    for (int k = 0; k < SL; k++) applyStimulus(vec[k], S_SHIFT, 1'b1, NM'($urandom), mi);
    applyStimulus(1'b0, S_UPD, 1'b1, NM'($urandom), mi);
  endtask

  task automatic doReset();
    @(negedge tck);
    trst       = 1'b1;
    shift_dr   = 1'b0;
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    mtdo       = NM'($urandom);
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_select", 64'(msel), 64'h1);
    @(negedge tck);
    trst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [SL-1:0] vec;
    int            seq[8];

    tbl[0] = '{id: 3,  inh: 5'b00000, exp_sel: 5'b01000, exp_err: 1'b0, exp_tdo: 1'b1};
    tbl[1] = '{id: 1,  inh: 5'b01000, exp_sel: 5'b01000, exp_err: 1'b1, exp_tdo: 1'b1};
    tbl[2] = '{id: 7,  inh: 5'b00000, exp_sel: 5'b00000, exp_err: 1'b1, exp_tdo: 1'b0};
    tbl[3] = '{id: 2,  inh: 5'b00000, exp_sel: 5'b00100, exp_err: STAT_EN, exp_tdo: 1'b1};
    tbl[4] = '{id: 31, inh: 5'b00000, exp_sel: 5'b00000, exp_err: 1'b1, exp_tdo: 1'b0};
    tbl[5] = '{id: 0,  inh: 5'b00000, exp_sel: 5'b00001, exp_err: STAT_EN, exp_tdo: 1'b1};
    seq = '{1, 1, 1, 1, 1, 0, 0, 1};

    trst = 1'b1; tdi = 1'b0; shift_dr = 1'b0; capture_dr = 1'b0; update_dr = 1'b0;
    dsel = 1'b0; mtdo = '0; minh = '0;
    modelReset();
    doReset();
    checkOutput("rst_err", 64'(serr), 64'h0);

    // Module 0 drives tdo straight out of reset.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, S_NONE, 1'b1, (v % 2) ? 5'b00001 : 5'b11110, 5'b0);
      checkOutput("tdo_module0", 64'(tdo), 64'(v % 2));
    end

    for (int i = 0; i < 6; i++) begin
      shiftCommand(tbl[i].id, tbl[i].inh);
      applyStimulus(1'b0, S_NONE, 1'b1, 5'b11111, 5'b0);
      checkOutput($sformatf("tbl%0d_select", i), 64'(msel), 64'(tbl[i].exp_sel));
      checkOutput($sformatf("tbl%0d_err", i), 64'(serr), 64'(tbl[i].exp_err));
      checkOutput($sformatf("tbl%0d_tdo", i), 64'(tdo), 64'(tbl[i].exp_tdo));
      applyStimulus(1'b0, S_NONE, 1'b1, 5'b00000, 5'b0);
      checkOutput($sformatf("tbl%0d_tdo_low", i), 64'(tdo), 64'h0);
    end

`ifdef ADBG_SELECT_STATUS_EN
    // Status readback after an inhibited select, then read-clear of the flags.
    doReset();
    shiftCommand(3, 5'b00000);
    shiftCommand(1, 5'b01000);
    shiftCommand(31, 5'b00000);
    checkOutput("stat_err_before", 64'(serr), 64'h1);
    applyStimulus(1'b0, S_CAP, 1'b1, 5'b11111, 5'b0);
    checkOutput("stat_err_cleared", 64'(serr), 64'h0);
    checkOutput("stat_bit0", 64'(tdo), 64'(seq[0]));
    for (int k = 1; k < 8; k++) begin
      applyStimulus(1'b0, S_SHIFT, 1'b1, 5'b11111, 5'b0);
      checkOutput($sformatf("stat_bit%0d", k), 64'(tdo), 64'(seq[k]));
    end
`endif

    // Reset in the middle of shifting a select for module 3.
    doReset();
    vec = {$urandom, $urandom};
    vec[SL-1] = 1'b1;
    vec[SL-2 -: IW] = IW'(3);
    for (int k = 0; k < 30; k++) applyStimulus(vec[k], S_SHIFT, 1'b1, NM'($urandom), 5'b0);
    @(negedge tck);
    #2;
    trst = 1'b1;
    #1;
    modelReset();
    checkOutput("midrst_dr", 64'(dr), 64'h0);
    checkOutput("midrst_select", 64'(msel), 64'h1);
    @(negedge tck);
    trst = 1'b0;
    shift_dr = 1'b0;
    applyStimulus(1'b0, S_UPD, 1'b1, NM'($urandom), 5'b0);
    checkOutput("midrst_no_commit", 64'(msel), 64'h1);
    checkOutput("midrst_err", 64'(serr), 64'h0);

    // Random traffic against the model.
    doReset();
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        int id = ($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 7);
        shiftCommand(id, ($urandom_range(0, 5) == 0) ? NM'($urandom) : '0);
      end else begin
        int s = $urandom_range(0, 9);
        int st = (s < 5) ? S_SHIFT : (s < 7) ? S_NONE : (s == 7) ? S_CAP :
                 (s == 8) ? S_UPD : S_CU;
        applyStimulus(1'($urandom), st, ($urandom_range(0, 9) != 0), NM'($urandom),
                      ($urandom_range(0, 7) == 0) ? NM'($urandom) : '0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adbg_chain_select.md
# adbg_chain_select

Parametrised successor to the debug top-level module-select logic. It owns the JTAG data-register input shift chain and decodes module-select commands into one-hot selects for any number of debug modules. It multiplexes module TDO outputs and adds things the fixed-size version lacked: out-of-range and inhibited selection detection with sticky error flags, and an optional status chain readable over JTAG. It sits between the TAP controller and the debug sub-modules (bus and CPU modules).

## Interface

Parameters:
- N_MODULES, 5, number of attached debug modules; must satisfy N_MODULES <= 2^ID_WIDTH - 1
- ID_WIDTH, 5, module ID field width
- SHIFT_LEN, 53, data shift register length; must be >= ID_WIDTH + 1

Ports (one clock; reset is asynchronous and active-high):
- tck_i  in  1  JTAG clock; all state on rising edge
- trst_i  in  1  asynchronous active-high reset
- tdi_i  in  1  serial data in
- tdo_o  out  1  serial data out (combinational mux)
- shift_dr_i, capture_dr_i, update_dr_i  in  1 each  TAP state strobes
- debug_select_i  in  1  debug instruction active in IR
- data_register_o  out  SHIFT_LEN  input shift register contents, to all modules
- module_tdo_i  in  N_MODULES  per-module TDO
- module_inhibit_i  in  N_MODULES  per-module request to block reselection
- module_select_o  out  N_MODULES  one-hot module select
- select_err_o  out  1  OR of sticky error flags

## Operation

- Shift register: when debug_select_i && shift_dr_i, it loads {tdi_i, sr[SHIFT_LEN-1:1]}. Reset value is 0.
- The command fields are select_cmd = sr[SHIFT_LEN-1] and id_in = sr[SHIFT_LEN-2 -: ID_WIDTH].
- A select event is update_dr_i && debug_select_i && select_cmd. On a select event:
  - any module_inhibit_i set: id_reg and valid are unchanged; err_inh <= 1
  - else if id_in < N_MODULES: id_reg <= id_in, valid <= 1
  - else if id_in == STATUS_ID (2^ID_WIDTH-1) and the status chain is compiled in: id_reg <= id_in, valid <= 0, no error
  - else: id_reg <= id_in, valid <= 0, err_rng <= 1
- module_select_o is the one-hot decode of id_reg when valid; it is all-zero otherwise.
- tdo_o is driven as follows:
  - valid: module_tdo_i[id_reg]
  - status mode (id_reg == STATUS_ID, feature enabled): stat_sr[0]
  - otherwise: 0
- select_err_o = err_inh | err_rng.
- Reset values:
  - id_reg = 0, valid = 1, so module 0 is selected and module_select_o = 1
  - err flags = 0, sr = 0, stat_sr = 0
  - tdo_o = module_tdo_i[0]
- Reset asserted mid-shift or mid-transaction clears all state immediately; no partial commit.

## Timing

- A select takes effect on the tck_i edge where update_dr_i is sampled. module_select_o and the tdo_o source change in the following cycle.
- A shift captures tdi_i on each rising edge. There are no extra pipeline stages, and data_register_o is the register output directly.
- Simultaneous capture_dr_i and update_dr_i is illegal from the TAP. If it occurs, update has priority and capture is ignored.
- An error-flag set and an error-flag clear in the same cycle resolve to set.
- Strobes with debug_select_i low are ignored entirely.

## Configuration

ADBG_SELECT_STATUS_EN:
- Defined:
  - STATUS_ID selects status mode.
  - On capture_dr_i && debug_select_i in status mode, stat_sr (ID_WIDTH+3 bits) loads {err_inh, err_rng, valid, id_reg}, and both error flags clear in that same cycle (read-clear).
  - On shift_dr_i in status mode, stat_sr shifts right with zero fill, LSB first on tdo_o.
- Undefined:
  - No stat_sr is built, and STATUS_ID is treated as out of range (err_rng set).
  - Error flags clear only on a successful select (id_in < N_MODULES).

## Structure

- Shared package adbg_pkg holds:
  - the STATUS_ID function of ID_WIDTH
  - status bit position constants (STAT_ERR_INH, STAT_ERR_RNG, STAT_VALID, STAT_ID_LSB)
  - the select-command bit position constant
- One sub-module, adbg_status_chain, contains the capture/shift status register, and is instantiated only under ADBG_SELECT_STATUS_EN.
- Decode, muxing and the error flags live in the top.

## Test plan

Defaults throughout (N_MODULES=5, ID_WIDTH=5, SHIFT_LEN=53).

1. Reset, then release -> module_select_o=5'b00001, select_err_o=0, and tdo_o tracks module_tdo_i[0].
2. Shift 53 bits with bit52=1, bits51:47=3, then update -> module_select_o=5'b01000; toggling module_tdo_i[3] appears on tdo_o.
3. With module_inhibit_i=5'b01000, select ID 1 -> module_select_o stays 5'b01000, select_err_o=1.
4. Select ID 7 -> module_select_o=0, tdo_o=0, select_err_o=1; then select ID 2 -> module_select_o=5'b00100, and the error stays set only with the macro enabled.
5. (Macro enabled) After case 3, select ID 31, capture, shift 8 -> tdo_o sequence LSB first is 1,1,1,1,1,0,0,1; select_err_o=0 after capture.
6. Assert trst_i mid-way through a 53-bit shift -> data_register_o=0, module_select_o=5'b00001, no update commits.
